hack_cpu_ctrl: RTL and testbench
================================

# hack_cpu_ctrl

Multi-cycle sequencer for the Hack-style CPU. It fetches 16-bit instructions from instruction memory, decodes A- and C-instructions, and drives the control inputs of the existing combinational `alu` (zx, nx, zy, ny, f, no). It owns the A, D and PC registers, sequences data-memory read and write handshakes, and resolves jumps from the ALU's zr/ng flags. It sits between the instruction ROM port, the data RAM port and the ALU datapath.

## Interface
Parameters:
- ADDR_W, 15, instruction and data address width (PC and memory address).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- instr_req  out  1  instruction fetch request.
- instr_addr  out  ADDR_W  fetch address, equal to PC.
- instr_data  in  16  fetched instruction.
- instr_valid  in  1  fetch complete; instr_data is valid this cycle.
- mem_req  out  1  data memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  out  ADDR_W  data address, taken from A[ADDR_W-1:0].
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data.
- mem_ready  in  1  data transfer complete this cycle.
- pc  out  ADDR_W  current PC, for debug.

## Operation
- FSM states:
  - FETCH: instr_req=1, instr_addr=PC. On instr_valid, latch IR. Go to DECODE.
  - DECODE:
    - IR[15]=0 (A-instruction): A<=IR, PC<=PC+1, go to FETCH.
    - IR[15]=1 and IR[12]=1 (a-bit, y=M): go to MREAD.
    - Otherwise: go to EXEC.
  - MREAD: mem_req=1, mem_we=0, mem_addr=A. On mem_ready, latch MREG<=mem_rdata. Go to EXEC.
  - EXEC: drive ALU with x=D, y=(a ? MREG : A), and control bits IR[11:6] = zx,nx,zy,ny,f,no.
    - Capture WADDR<=A and WDATA<=alu out, both using the old A.
    - If d1 (IR[5]) is set, A<=out. If d2 (IR[4]) is set, D<=out.
    - Jump if (j1&ng) | (j2&zr) | (j3&!zr&!ng), with j = IR[2:0]. On a jump, PC<=old A; otherwise PC<=PC+1.
    - If d3 (IR[3]) is set, go to MWRITE; otherwise go to FETCH.
  - MWRITE: mem_req=1, mem_we=1, mem_addr=WADDR, mem_wdata=WDATA. On mem_ready, go to FETCH.
- IR[14:13] is ignored; every IR[15]=1 word executes as a C-instruction.
- Arithmetic: all ALU data is 16-bit. PC increment wraps modulo 2^ADDR_W (max → 0). Jump target and memory address are A[ADDR_W-1:0].
- Reset, including mid-transaction: state=FETCH; PC, A, D, IR, MREG, WADDR and WDATA all reset to 0. instr_req, mem_req and mem_we drop on the same edge. An outstanding request is abandoned, and a late valid/ready is ignored unless it arrives in FETCH.

## Timing
- Request outputs are registered from the state. Once asserted, instr_req/mem_req and the address, we and wdata outputs are held stable until the cycle in which valid/ready is sampled high.
- Zero-wait response is allowed: valid/ready may be high in the first cycle of the request.
- mem_req deasserts in the cycle after mem_ready, so back-to-back transfers are never merged.
- Cycle counts with zero-wait memory:
  - A-instruction: 2 cycles.
  - C-instruction without M: 3 cycles.
  - +1 cycle for an M read.
  - +1 cycle for an M write.
  - Worst case (read + write): 5 cycles.
- Each wait cycle on instr_valid or mem_ready adds exactly 1 cycle.
- Reset values: instr_req=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr_addr=0, pc=0. The first fetch request is issued in the cycle after rst_n rises.

## Structure
- Package `hack_pkg`:
  - state enum (FETCH, DECODE, MREAD, EXEC, MWRITE);
  - instruction field bit positions (A_FLAG=15, A_BIT=12, C_MSB=11, C_LSB=6, D_A=5, D_D=4, D_M=3, J_LT=2, J_EQ=1, J_GT=0);
  - NOP encoding.
- Sub-module: one instance of the existing `alu`. Jump evaluation stays inline.

## Test plan
- Reset, then @5 (0x0005) then D=A (0xEC10): A=0x0005, D=0x0005, PC=2, no mem_req ever asserted; 5 cycles total.
- With D=5 and A=0x0040, D;JGT (0xE301): PC=0x0040. Repeat with D=0: PC=old PC+1.
- With A=0x0010 and D=5, M=D+1 (0xE7C8), mem_ready delayed 3 cycles: mem_addr=0x0010, mem_wdata=0x0006 and mem_we=1 all held stable for 4 cycles.
- With A=0x0020 and mem_rdata=0x0001, AM=M-1 (0xFCA8): one read at 0x0020, then a write of 0x0000 to 0x0020 (old A); A=0 afterwards.
- With PC=0x7FFF executing @1: PC wraps to 0. Then 0;JMP (0xEA87) with A=0x1234: PC=0x1234.
- Assert rst_n=0 during MWRITE while mem_ready=0: mem_req drops on the next edge, PC=A=D=0, and the first request after release is a fetch at address 0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU sequencer: FSM states, instruction
// field positions and the canonical no-op word.
package hack_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MREAD,
    EXEC,
    MWRITE
  } state_t;

  localparam int A_FLAG = 15;
  localparam int A_BIT  = 12;
  localparam int C_MSB  = 11;
  localparam int C_LSB  = 6;
  localparam int D_A    = 5;
  localparam int D_D    = 4;
  localparam int D_M    = 3;
  localparam int J_LT   = 2;
  localparam int J_EQ   = 1;
  localparam int J_GT   = 0;

  // "0" with no destination and no jump
  localparam logic [15:0] NOP = 16'hEA80;

endpackage

// File: rtl/alu.sv
// Combinational Hack ALU: optional zero/negate of each operand, add or AND,
// optional output negate, plus zero and negative flags.
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] xs;
  logic [15:0] ys;
  logic [15:0] res;

  always_comb begin
    xs  = zx ? 16'h0000 : x;
    xs  = nx ? ~xs : xs;
    ys  = zy ? 16'h0000 : y;
    ys  = ny ? ~ys : ys;
    res = f ? (xs + ys) : (xs & ys);
    out = no ? ~res : res;
  end

  assign zr = (out == 16'h0000);
  assign ng = out[15];

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU sequencer: fetch, decode, optional M read, execute
// through the ALU, optional M write. All bus outputs are registered.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [15:0]       instr_data,
  input  logic              instr_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc
);

  state_t            state;
  logic [15:0]       ir;
  logic [15:0]       a;
  logic [15:0]       d;
  logic [15:0]       mreg;

  logic [15:0]       alu_out;
  logic              alu_zr;
  logic              alu_ng;
  logic              jump;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_exec;

  alu u_alu (
    .x   (d),
    .y   (ir[A_BIT] ? mreg : a),
    .zx  (ir[C_MSB]),
    .nx  (ir[C_MSB-1]),
    .zy  (ir[C_MSB-2]),
    .ny  (ir[C_MSB-3]),
    .f   (ir[C_LSB+1]),
    .no  (ir[C_LSB]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign jump    = (ir[J_LT] & alu_ng) | (ir[J_EQ] & alu_zr) | (ir[J_GT] & ~alu_zr & ~alu_ng);
  assign pc_inc  = pc + ADDR_W'(1);
  assign pc_exec = jump ? a[ADDR_W-1:0] : pc_inc;

  // Bits 14:13 of a C-instruction carry no meaning.
  logic unused_ir_bits;
  assign unused_ir_bits = &{1'b0, ir[14:13]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= '0;
      a          <= '0;
      d          <= '0;
      ir         <= '0;
      mreg       <= '0;
      instr_req  <= 1'b0;
      instr_addr <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        FETCH: begin
          // Right after reset no request is pending yet, so raise it first.
          if (!instr_req) begin
            instr_req  <= 1'b1;
            instr_addr <= pc;
          end else if (instr_valid) begin
            ir        <= instr_data;
            instr_req <= 1'b0;
            state     <= DECODE;
          end
        end
        DECODE: begin
          if (!ir[A_FLAG]) begin
            a          <= ir;
            pc         <= pc_inc;
            instr_req  <= 1'b1;
            instr_addr <= pc_inc;
            state      <= FETCH;
          end else if (ir[A_BIT]) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= a[ADDR_W-1:0];
            state    <= MREAD;
          end else begin
            state <= EXEC;
          end
        end
        MREAD: begin
          if (mem_ready) begin
            mreg    <= mem_rdata;
            mem_req <= 1'b0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // Write address and data are taken before A can be overwritten.
          mem_addr  <= a[ADDR_W-1:0];
          mem_wdata <= alu_out;
          if (ir[D_A]) a <= alu_out;
          if (ir[D_D]) d <= alu_out;
          pc <= pc_exec;
          if (ir[D_M]) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            state   <= MWRITE;
          end else begin
            instr_req  <= 1'b1;
            instr_addr <= pc_exec;
            state      <= FETCH;
          end
        end
        MWRITE: begin
          if (mem_ready) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            instr_req  <= 1'b1;
            instr_addr <= pc;
            state      <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: directed scenarios plus random
// programs checked against an instruction-level Hack reference model.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req;
  logic [14:0] instr_addr;
  logic [15:0] instr_data = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ready = 1'b0;
  logic [14:0] pc;

  hack_cpu_ctrl #(.ADDR_W(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_data  (instr_data),
    .instr_valid (instr_valid),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [14:0] fetch_addr;
    int          cycles;
    int          rd_cnt;
    logic [14:0] rd_addr;
    int          wr_cnt;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    int          mem_cycles;
    bit          proto_ok;
    bit          timeout;
  } obs_t;

  typedef struct {
    logic [14:0] fetch_addr;
    int          cycles;
    bit          rd;
    logic [14:0] rd_addr;
    bit          wr;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic [14:0] next_pc;
  } exp_t;

  // Architectural state of the reference machine
  logic [15:0] m_a;
  logic [15:0] m_d;
  logic [14:0] m_pc;

  logic [5:0] codes [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                             6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                             6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                             6'b000111, 6'b000000, 6'b010101};

  // Hack comp mnemonics evaluated directly
  function automatic logic [15:0] comp(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return x;
      6'b110000: return y;
      6'b001101: return ~x;
      6'b110001: return ~y;
      6'b001111: return 16'd0 - x;
      6'b110011: return 16'd0 - y;
      6'b011111: return x + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return x - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return x + y;
      6'b010011: return x - y;
      6'b000111: return y - x;
      6'b000000: return x & y;
      6'b010101: return x | y;
      default:   return 16'hxxxx;
    endcase
  endfunction

  task automatic model_exec(input logic [15:0] instr, input logic [15:0] rdata,
                            input int iw, input int mw, output exp_t e);
    logic [15:0] out;
    bit lt, eq, gt, jmp;
    e = '{default: 0};
    e.fetch_addr = m_pc;
    if (!instr[15]) begin
      m_a = instr;
      m_pc = m_pc + 15'd1;
      e.cycles = 2 + iw;
    end else begin
      out = comp(instr[11:6], m_d, instr[12] ? rdata : m_a);
      lt = $signed(out) < 0;
      eq = (out == 16'd0);
      gt = !lt && !eq;
      jmp = (instr[2] && lt) || (instr[1] && eq) || (instr[0] && gt);
      e.rd = instr[12];
      e.wr = instr[3];
      e.rd_addr = m_a[14:0];
      e.wr_addr = m_a[14:0];
      e.wr_data = out;
      e.cycles = 3 + iw + (e.rd ? 1 + mw : 0) + (e.wr ? 1 + mw : 0);
      m_pc = jmp ? m_a[14:0] : m_pc + 15'd1;
      if (instr[5]) m_a = out;
      if (instr[4]) m_d = out;
    end
    e.next_pc = m_pc;
  endtask

  // Acts as instruction ROM and data RAM for one instruction, recording what the DUT did.
  task automatic exec_instr(input logic [15:0] instr, input int iw, input int mw,
                            input logic [15:0] rdata, output obs_t o);
    int n, w;
    bit busy, rdy_prev;
    logic [14:0] h_addr;
    logic h_we;
    logic [15:0] h_wdata;
    o = '{default: 0};
    o.proto_ok = 1'b1;
    h_addr = '0; h_we = 1'b0; h_wdata = '0;
    n = 0;
    while (instr_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (instr_req !== 1'b1) begin o.timeout = 1'b1; return; end
    o.fetch_addr = instr_addr;
    for (int k = 0; k <= iw; k++) begin
      if (instr_req !== 1'b1 || instr_addr !== o.fetch_addr) o.proto_ok = 1'b0;
      instr_valid = (k == iw);
      instr_data = (k == iw) ? instr : ~instr;
      @(negedge clk);
      o.cycles++;
    end
    instr_valid = 1'b0;
    busy = 1'b0; rdy_prev = 1'b0; w = 0; n = 0;
    while (instr_req !== 1'b1 && n < 200) begin
      mem_ready = 1'b0;
      mem_rdata = ~rdata;
      if (rdy_prev && mem_req === 1'b1) o.proto_ok = 1'b0;
      rdy_prev = 1'b0;
      if (mem_req === 1'b1) begin
        o.mem_cycles++;
        if (!busy) begin
          busy = 1'b1; w = 0;
          h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        end else if (mem_addr !== h_addr || mem_we !== h_we || (h_we && mem_wdata !== h_wdata)) begin
          o.proto_ok = 1'b0;
        end
        if (w == mw) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
          busy = 1'b0;
          rdy_prev = 1'b1;
          if (h_we) begin o.wr_cnt++; o.wr_addr = h_addr; o.wr_data = h_wdata; end
          else begin o.rd_cnt++; o.rd_addr = h_addr; end
        end else begin
          w++;
        end
      end
      @(negedge clk);
      o.cycles++;
      n++;
    end
    mem_ready = 1'b0;
    if (rdy_prev && mem_req === 1'b1) o.proto_ok = 1'b0;
    if (instr_req !== 1'b1) o.timeout = 1'b1;
  endtask

  task automatic step(input logic [15:0] instr, input int iw, input int mw,
                      input logic [15:0] rdata, output obs_t o, output exp_t e);
    model_exec(instr, rdata, iw, mw, e);
    exec_instr(instr, iw, mw, rdata, o);
    $display("instr %h @%h: cycles=%0d rd=%0d wr=%0d(%h<-%h) pc=%h", instr, o.fetch_addr,
             o.cycles, o.rd_cnt, o.wr_cnt, o.wr_addr, o.wr_data, pc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if ({instr_req, mem_req, mem_we} !== 3'b000) $display("FAIL reset_req: got %b want 000", {instr_req, mem_req, mem_we}); else n_pass++;
    n_total++; if (instr_addr !== 15'd0 || pc !== 15'd0) $display("FAIL reset_pc: got addr=%h pc=%h want 0", instr_addr, pc); else n_pass++;
    n_total++; if (mem_addr !== 15'd0 || mem_wdata !== 16'd0) $display("FAIL reset_mem: got addr=%h wdata=%h want 0", mem_addr, mem_wdata); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (instr_req !== 1'b1 || instr_addr !== 15'd0) $display("FAIL first_fetch: got req=%b addr=%h want 1/0", instr_req, instr_addr); else n_pass++;
    m_a = 16'd0; m_d = 16'd0; m_pc = 15'd0;
    $display("reset done");
  endtask

  task automatic test_a_then_d();
    obs_t o1, o2, o3;
    exp_t e1, e2, e3;
    step(16'h0005, 0, 0, 16'h0, o1, e1);
    step(16'hEC10, 0, 0, 16'h0, o2, e2);
    n_total++; if (o1.cycles + o2.cycles !== 5) $display("FAIL ad_cycles: got %0d want 5", o1.cycles + o2.cycles); else n_pass++;
    n_total++; if (pc !== 15'd2) $display("FAIL ad_pc: got %h want 0002", pc); else n_pass++;
    n_total++; if (o1.mem_cycles + o2.mem_cycles !== 0) $display("FAIL ad_no_mem: got %0d mem cycles want 0", o1.mem_cycles + o2.mem_cycles); else n_pass++;
    step(16'hE308, 0, 0, 16'h0, o3, e3);
    n_total++; if (o3.wr_cnt !== 1 || o3.wr_addr !== 15'h0005 || o3.wr_data !== 16'h0005) $display("FAIL ad_regs: got wr=%0d %h<-%h want 1 0005<-0005", o3.wr_cnt, o3.wr_addr, o3.wr_data); else n_pass++;
  endtask

  task automatic test_jump();
    obs_t o;
    exp_t e;
    step(16'h0005, 0, 0, 16'h0, o, e);
    step(16'hEC10, 0, 0, 16'h0, o, e);
    step(16'h0040, 0, 0, 16'h0, o, e);
    step(16'hE301, 0, 0, 16'h0, o, e);
    n_total++; if (pc !== 15'h0040 || instr_addr !== 15'h0040) $display("FAIL jgt_taken: got pc=%h addr=%h want 0040", pc, instr_addr); else n_pass++;
    step(16'h0000, 0, 0, 16'h0, o, e);
    step(16'hEC10, 0, 0, 16'h0, o, e);
    step(16'h0040, 0, 0, 16'h0, o, e);
    step(16'hE301, 1, 0, 16'h0, o, e);
    n_total++; if (pc !== o.fetch_addr + 15'd1 || pc !== e.next_pc) $display("FAIL jgt_not_taken: got pc=%h want %h", pc, e.next_pc); else n_pass++;
    n_total++; if (o.cycles !== 4) $display("FAIL fetch_wait_cycles: got %0d want 4", o.cycles); else n_pass++;
  endtask

  task automatic test_write_wait();
    obs_t o;
    exp_t e;
    step(16'h0005, 0, 0, 16'h0, o, e);
    step(16'hEC10, 0, 0, 16'h0, o, e);
    step(16'h0010, 0, 0, 16'h0, o, e);
    step(16'hE7C8, 0, 3, 16'h0, o, e);
    n_total++; if (o.wr_cnt !== 1 || o.rd_cnt !== 0 || o.wr_addr !== 15'h0010 || o.wr_data !== 16'h0006) $display("FAIL wwait_data: got wr=%0d rd=%0d %h<-%h want 1 0 0010<-0006", o.wr_cnt, o.rd_cnt, o.wr_addr, o.wr_data); else n_pass++;
    n_total++; if (o.mem_cycles !== 4 || !o.proto_ok) $display("FAIL wwait_hold: got %0d cycles stable=%0b want 4 1", o.mem_cycles, o.proto_ok); else n_pass++;
    n_total++; if (o.cycles !== 7 || o.cycles !== e.cycles) $display("FAIL wwait_cycles: got %0d want 7", o.cycles); else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    step(16'h0020, 0, 0, 16'h0, o, e);
    step(16'hFCA8, 0, 0, 16'h0001, o, e);
    n_total++; if (o.rd_cnt !== 1 || o.rd_addr !== 15'h0020) $display("FAIL rw_read: got %0d reads at %h want 1 at 0020", o.rd_cnt, o.rd_addr); else n_pass++;
    n_total++; if (o.wr_cnt !== 1 || o.wr_addr !== 15'h0020 || o.wr_data !== 16'h0000) $display("FAIL rw_write: got %0d %h<-%h want 1 0020<-0000", o.wr_cnt, o.wr_addr, o.wr_data); else n_pass++;
    n_total++; if (o.cycles !== 5 || !o.proto_ok) $display("FAIL rw_cycles: got %0d ok=%0b want 5 1", o.cycles, o.proto_ok); else n_pass++;
    step(16'hEC08, 0, 0, 16'h0, o, e);
    n_total++; if (o.wr_addr !== 15'h0000 || o.wr_data !== 16'h0000) $display("FAIL rw_a_after: got %h<-%h want 0000<-0000", o.wr_addr, o.wr_data); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    obs_t o;
    exp_t e;
    step(16'h7FFF, 0, 0, 16'h0, o, e);
    step(16'hEA87, 0, 0, 16'h0, o, e);
    n_total++; if (pc !== 15'h7FFF) $display("FAIL wrap_setup: got %h want 7fff", pc); else n_pass++;
    step(16'h0001, 0, 0, 16'h0, o, e);
    n_total++; if (pc !== 15'h0000 || instr_addr !== 15'h0000) $display("FAIL pc_wrap: got pc=%h addr=%h want 0000", pc, instr_addr); else n_pass++;
    step(16'h1234, 0, 0, 16'h0, o, e);
    step(16'hEA87, 0, 0, 16'h0, o, e);
    n_total++; if (pc !== 15'h1234) $display("FAIL jmp: got %h want 1234", pc); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    exp_t e;
    int n;
    step(16'h0007, 0, 0, 16'h0, o, e);
    step(16'hEC10, 0, 0, 16'h0, o, e);
    step(16'h0010, 0, 0, 16'h0, o, e);
    instr_valid = 1'b1;
    instr_data = 16'hE308;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && n < 10) begin @(negedge clk); n++; end
    n_total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) $display("FAIL midrst_write_seen: got req=%b we=%b want 1 1", mem_req, mem_we); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_total++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || instr_req !== 1'b0) $display("FAIL midrst_drop: got mreq=%b we=%b ireq=%b want 000", mem_req, mem_we, instr_req); else n_pass++;
    n_total++; if (pc !== 15'd0) $display("FAIL midrst_pc: got %h want 0000", pc); else n_pass++;
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    n_total++; if (instr_req !== 1'b1 || instr_addr !== 15'd0 || mem_req !== 1'b0) $display("FAIL midrst_refetch: got ireq=%b addr=%h mreq=%b want 1 0000 0", instr_req, instr_addr, mem_req); else n_pass++;
    m_a = 16'd0; m_d = 16'd0; m_pc = 15'd0;
    step(16'hE308, 0, 0, 16'h0, o, e);
    n_total++; if (o.wr_addr !== 15'd0 || o.wr_data !== 16'd0 || pc !== 15'd1) $display("FAIL midrst_regs: got %h<-%h pc=%h want 0000<-0000 pc=0001", o.wr_addr, o.wr_data, pc); else n_pass++;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [15:0] instr;
    int iw, mw;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 99) < 35) instr = {1'b0, 15'($urandom)};
      else instr = {3'b111, 1'($urandom), codes[$urandom_range(0, 17)], 6'($urandom)};
      iw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      step(instr, iw, mw, 16'($urandom), o, e);
      n_total++; if (o.timeout || o.fetch_addr !== e.fetch_addr) $display("FAIL rnd_fetch[%0d]: got %h to=%0b want %h", i, o.fetch_addr, o.timeout, e.fetch_addr); else n_pass++;
      n_total++; if (o.cycles !== e.cycles || !o.proto_ok) $display("FAIL rnd_timing[%0d]: got %0d ok=%0b want %0d", i, o.cycles, o.proto_ok, e.cycles); else n_pass++;
      n_total++; if (o.rd_cnt !== int'(e.rd) || (e.rd && o.rd_addr !== e.rd_addr)) $display("FAIL rnd_read[%0d]: got %0d at %h want %0d at %h", i, o.rd_cnt, o.rd_addr, e.rd, e.rd_addr); else n_pass++;
      n_total++; if (o.wr_cnt !== int'(e.wr) || (e.wr && (o.wr_addr !== e.wr_addr || o.wr_data !== e.wr_data))) $display("FAIL rnd_write[%0d]: got %0d %h<-%h want %0d %h<-%h", i, o.wr_cnt, o.wr_addr, o.wr_data, e.wr, e.wr_addr, e.wr_data); else n_pass++;
      n_total++; if (pc !== e.next_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, e.next_pc); else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_a_then_d();
    test_jump();
    test_write_wait();
    test_back_to_back();
    test_pc_wrap();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
